// File: rtl/xgmii_lane_align.sv
// Realigns an XGMII receive stream so that a Start character always lands in lane 0.
// Start lanes must sit on ALIGN boundaries. Misplaced Starts force Idle output until the next legal Start.
module xgmii_lane_align #(
  parameter int LANES = 8,
  parameter int ALIGN = 4,
  parameter int CNT_W = 16
) (
  input  logic                     xgmii_rx_clk,
  input  logic                     sys_rst,
  input  logic [8*LANES-1:0]       rx_data_i,
  input  logic [LANES-1:0]         rx_ctrl_i,
  input  logic                     clr_cnt_i,
  output logic [8*LANES-1:0]       rx_data_o,
  output logic [LANES-1:0]         rx_ctrl_o,
  output logic                     sof_o,
  output logic [$clog2(LANES)-1:0] shift_o,
  output logic                     locked_o,
  output logic                     misalign_err_o,
  output logic [CNT_W-1:0]         realign_cnt_o
);

  localparam int SW = $clog2(LANES);
  localparam int DW = 8 * LANES;
  localparam logic [7:0] START_CH = 8'hFB;
  localparam logic [7:0] IDLE_CH  = 8'h07;
  localparam logic [DW-1:0]    IDLE_DATA = {LANES{IDLE_CH}};
  localparam logic [LANES-1:0] IDLE_CTRL = {LANES{1'b1}};

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q;
  logic [SW-1:0]    shift_q;
  logic [DW-1:0]    prev_data_q;
  logic [LANES-1:0] prev_ctrl_q;
  logic             err_pipe_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    data_q;
  logic [LANES-1:0] ctrl_q;
  logic             sof_q;
  logic             err_q;

  logic             start_found;
  logic [SW-1:0]    start_lane;
  logic             start_legal;
  logic             start_illegal;
  logic             cnt_inc;
  logic [DW-1:0]    shifted_data;
  logic [LANES-1:0] shifted_ctrl;

  // Descending scan so the lowest-indexed Start lane wins.
  always_comb begin
    start_found = 1'b0;
    start_lane  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rx_ctrl_i[i] && (rx_data_i[8*i +: 8] == START_CH)) begin
        start_found = 1'b1;
        start_lane  = SW'(i);
      end
    end
  end

  assign start_legal   = start_found && ((int'(start_lane) % ALIGN) == 0);
  assign start_illegal = start_found && !start_legal;
  assign cnt_inc       = start_legal && ((state_q == HUNT) || (start_lane != shift_q));

  // Output lane k is byte k+shift of the {current, prev} stream.
  assign shifted_data = DW'({rx_data_i, prev_data_q} >> {shift_q, 3'b000});
  assign shifted_ctrl = LANES'({rx_ctrl_i, prev_ctrl_q} >> shift_q);

  always_ff @(posedge xgmii_rx_clk) begin
    if (sys_rst) begin
      state_q     <= HUNT;
      shift_q     <= '0;
      prev_data_q <= IDLE_DATA;
      prev_ctrl_q <= IDLE_CTRL;
      err_pipe_q  <= 1'b0;
      cnt_q       <= '0;
      data_q      <= IDLE_DATA;
      ctrl_q      <= IDLE_CTRL;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_data_q <= rx_data_i;
      prev_ctrl_q <= rx_ctrl_i;
      err_pipe_q  <= start_illegal;
      err_q       <= err_pipe_q;

      case (state_q)
        HUNT: begin
          if (start_legal) begin
            state_q <= LOCKED;
            shift_q <= start_lane;
          end
        end
        LOCKED: begin
          if (start_legal) begin
            shift_q <= start_lane;
          end else if (start_illegal) begin
            state_q <= HUNT;
          end
        end
        default: state_q <= HUNT;
      endcase

      if (clr_cnt_i) begin
        cnt_q <= '0;
      end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // state_q here reflects the word now held in prev, i.e. the one being emitted.
      if (state_q == LOCKED) begin
        data_q <= shifted_data;
        ctrl_q <= shifted_ctrl;
        sof_q  <= shifted_ctrl[0] && (shifted_data[7:0] == START_CH);
      end else begin
        data_q <= IDLE_DATA;
        ctrl_q <= IDLE_CTRL;
        sof_q  <= 1'b0;
      end
    end
  end

  assign rx_data_o      = data_q;
  assign rx_ctrl_o      = ctrl_q;
  assign sof_o          = sof_q;
  assign shift_o        = shift_q;
  assign locked_o       = (state_q == LOCKED);
  assign misalign_err_o = err_q;
  assign realign_cnt_o  = cnt_q;

endmodule

// File: tb/tb_xgmii_lane_align.sv
// Bench for xgmii_lane_align: an 8-lane (ALIGN=4, CNT_W=2) and a 16-lane (ALIGN=8) instance
// checked every cycle against a byte-level stream model, plus directed literal checks.
module tb_xgmii_lane_align;

  localparam int NC = 1024;
  localparam int NRAND = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  logic [63:0]  d8;  logic [7:0]  c8;
  logic [127:0] d16; logic [15:0] c16;

  logic [63:0]  od8;  logic [7:0]  oc8;  logic sof8;  logic [2:0] sh8;  logic lk8;  logic err8;  logic [1:0]  cnt8;
  logic [127:0] od16; logic [15:0] oc16; logic sof16; logic [3:0] sh16; logic lk16; logic err16; logic [15:0] cnt16;

  xgmii_lane_align #(.LANES(8), .ALIGN(4), .CNT_W(2)) u_l8 (
    .xgmii_rx_clk(clk), .sys_rst(rst), .rx_data_i(d8), .rx_ctrl_i(c8), .clr_cnt_i(clr),
    .rx_data_o(od8), .rx_ctrl_o(oc8), .sof_o(sof8), .shift_o(sh8), .locked_o(lk8),
    .misalign_err_o(err8), .realign_cnt_o(cnt8));

  xgmii_lane_align #(.LANES(16), .ALIGN(8), .CNT_W(16)) u_l16 (
    .xgmii_rx_clk(clk), .sys_rst(rst), .rx_data_i(d16), .rx_ctrl_i(c16), .clr_cnt_i(clr),
    .rx_data_o(od16), .rx_ctrl_o(oc16), .sof_o(sof16), .shift_o(sh16), .locked_o(lk16),
    .misalign_err_o(err16), .realign_cnt_o(cnt16));

  // Per-instance geometry of the model.
  int L_OF[2]    = '{8, 16};
  int A_OF[2]    = '{4, 8};
  int CMAX_OF[2] = '{3, 65535};

  // Model history, indexed by cycle.
  logic [127:0] h_d [2][NC];
  logic [15:0]  h_c [2][NC];
  bit           h_rst [NC];
  bit           h_clr [NC];
  bit           m_lk  [2][NC];
  int           m_sh  [2][NC];
  int           m_cnt [2][NC];
  bit           m_ill [2][NC];

  int cyc;
  int n_vec;
  int n_err;

  function automatic logic [7:0] lane_of(input logic [127:0] d, input int k);
    logic [127:0] t;
    t = d >> (8 * k);
    return t[7:0];
  endfunction

  function automatic bit bit_of(input logic [15:0] c, input int k);
    logic [15:0] t;
    t = c >> k;
    return t[0];
  endfunction

  function automatic logic [127:0] set_lane(input logic [127:0] d, input int k, input logic [7:0] b);
    logic [127:0] m, v;
    m = 128'hFF << (8 * k);
    v = {120'b0, b} << (8 * k);
    return (d & ~m) | v;
  endfunction

  function automatic logic [127:0] idle_d(input int L);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < L; k++) d = set_lane(d, k, 8'h07);
    return d;
  endfunction

  function automatic logic [15:0] idle_c(input int L);
    logic [16:0] t;
    t = (17'h1 << L) - 17'h1;
    return t[15:0];
  endfunction

  function automatic logic [127:0] rand_payload(input int L);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < L; k++) d = set_lane(d, k, 8'($urandom_range(0, 255)));
    return d;
  endfunction

  // Lowest lane carrying a Start character, or -1.
  function automatic int find_start(input logic [127:0] d, input logic [15:0] c, input int L);
    for (int k = 0; k < L; k++)
      if (bit_of(c, k) && lane_of(d, k) == 8'hFB) return k;
    return -1;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i, input int c);
    int L, A, p;
    bit legal, illegal, plk;
    int psh, pcnt;
    L = L_OF[i];
    A = A_OF[i];
    if (h_rst[c]) begin
      m_lk[i][c] = 0; m_sh[i][c] = 0; m_cnt[i][c] = 0; m_ill[i][c] = 0;
    end else begin
      plk = m_lk[i][c-1]; psh = m_sh[i][c-1]; pcnt = m_cnt[i][c-1];
      p = find_start(h_d[i][c], h_c[i][c], L);
      legal   = (p >= 0) && (p % A == 0);
      illegal = (p >= 0) && !legal;
      m_ill[i][c] = illegal;
      m_lk[i][c]  = legal ? 1'b1 : (illegal ? 1'b0 : plk);
      m_sh[i][c]  = legal ? p : psh;
      if (h_clr[c]) m_cnt[i][c] = 0;
      else if (legal && (!plk || p != psh)) m_cnt[i][c] = (pcnt < CMAX_OF[i]) ? pcnt + 1 : pcnt;
      else m_cnt[i][c] = pcnt;
    end
  endtask

  // Outputs visible just after edge c: slot of word c-1, state after word c.
  task automatic compare(input int i, input int c);
    int L, s, j;
    logic [127:0] ed, ad;
    logic [15:0]  ec, ac;
    bit es, ee, cb;
    logic [7:0] b;
    string tag;
    L = L_OF[i];
    tag = (i == 0) ? "l8" : "l16";
    if (h_rst[c]) begin
      ed = idle_d(L); ec = idle_c(L); es = 0; ee = 0;
    end else begin
      ee = m_ill[i][c-1];
      if (m_lk[i][c-1]) begin
        s = m_sh[i][c-1];
        ed = '0; ec = '0;
        for (int k = 0; k < L; k++) begin
          j = k + s;
          if (j < L) begin b = lane_of(h_d[i][c-1], j); cb = bit_of(h_c[i][c-1], j); end
          else begin b = lane_of(h_d[i][c], j - L); cb = bit_of(h_c[i][c], j - L); end
          ed = set_lane(ed, k, b);
          ec[k] = cb;
        end
        es = ec[0] && (ed[7:0] == 8'hFB);
      end else begin
        ed = idle_d(L); ec = idle_c(L); es = 0;
      end
    end
    ad = (i == 0) ? {64'b0, od8} : od16;
    ac = (i == 0) ? {8'b0, oc8} : oc16;
    check({tag, "_data"},   ad, ed);
    check({tag, "_ctrl"},   {112'b0, ac}, {112'b0, ec});
    check({tag, "_sof"},    (i == 0) ? 128'(sof8) : 128'(sof16), 128'(es));
    check({tag, "_err"},    (i == 0) ? 128'(err8) : 128'(err16), 128'(ee));
    check({tag, "_shift"},  (i == 0) ? 128'(sh8) : 128'(sh16), 128'(m_sh[i][c]));
    check({tag, "_locked"}, (i == 0) ? 128'(lk8) : 128'(lk16), 128'(m_lk[i][c]));
    check({tag, "_cnt"},    (i == 0) ? 128'(cnt8) : 128'(cnt16), 128'(m_cnt[i][c]));
  endtask

  task automatic step(input logic [127:0] a_d, input logic [15:0] a_c,
                      input logic [127:0] b_d, input logic [15:0] b_c,
                      input bit r, input bit cl);
    @(negedge clk);
    d8 = a_d[63:0]; c8 = a_c[7:0]; d16 = b_d; c16 = b_c; rst = r; clr = cl;
    @(posedge clk);
    #1;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC);
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "cycle budget exceeded");
    end
    h_d[0][cyc] = {64'b0, a_d[63:0]}; h_c[0][cyc] = {8'b0, a_c[7:0]};
    h_d[1][cyc] = b_d;                h_c[1][cyc] = b_c;
    h_rst[cyc] = r; h_clr[cyc] = cl;
    model_step(0, cyc); model_step(1, cyc);
    compare(0, cyc);    compare(1, cyc);
    cyc++;
  endtask

  task automatic gen_word(input int L, input int A, output logic [127:0] d, output logic [15:0] c);
    int r, p, q;
    r = $urandom_range(0, 9);
    d = rand_payload(L);
    c = '0;
    if (r < 2) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : A * $urandom_range(0, L / A - 1);
      d = set_lane(d, p, 8'hFB); c[p] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        q = $urandom_range(p, L - 1);
        d = set_lane(d, q, 8'hFB); c[q] = 1'b1;
      end
    end else if (r == 2) begin
      d = idle_d(L); c = idle_c(L);
    end else if (r == 3) begin
      c = 16'($urandom_range(0, 65535)) & idle_c(L);
    end
  endtask

  logic [127:0] I8D, I16D, wd, wd16, p8, p16;
  logic [15:0]  I8C, I16C;
  int seq[5] = '{4, 0, 4, 0, 4};
  int cexp[5] = '{1, 2, 3, 3, 3};

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    I8D = idle_d(8); I8C = idle_c(8); I16D = idle_d(16); I16C = idle_c(16);
    rst = 1'b1; clr = 1'b0; d8 = I8D[63:0]; c8 = I8C[7:0]; d16 = I16D; c16 = I16C;

    repeat (3) step(I8D, I8C, I16D, I16C, 1, 0);
    check("rst_data", {64'b0, od8}, {64'b0, 64'h0707070707070707});
    check("rst_ctrl", {120'b0, oc8}, {120'b0, 8'hFF});
    check("rst_locked", 128'(lk8), 128'(0));
    repeat (2) step(I8D, I8C, I16D, I16C, 0, 0);

    // Start in lane 0 from HUNT.
    wd = set_lane(rand_payload(8), 0, 8'hFB);
    step(wd, 16'h0001, I16D, I16C, 0, 0);
    check("l0_shift", 128'(sh8), 128'(0));
    check("l0_locked", 128'(lk8), 128'(1));
    check("l0_cnt", 128'(cnt8), 128'(1));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);
    check("l0_sof", 128'(sof8), 128'(1));
    check("l0_data", {64'b0, od8}, {64'b0, wd[63:0]});
    check("l0_ctrlout", {120'b0, oc8}, {120'b0, 8'h01});
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);

    // Start in lane 4 with preamble bytes behind it.
    wd = set_lane(rand_payload(8), 4, 8'hFB);
    for (int k = 5; k < 8; k++) wd = set_lane(wd, k, 8'hD5);
    step(wd, 16'h0010, I16D, I16C, 0, 0);
    check("l4_shift", 128'(sh8), 128'(4));
    check("l4_cnt", 128'(cnt8), 128'(2));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);
    check("l4_lane0", 128'(od8[7:0]), 128'(8'hFB));
    check("l4_lanes123", 128'(od8[31:8]), 128'(24'hD5D5D5));
    check("l4_sof", 128'(sof8), 128'(1));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);

    // Misaligned Start in lane 2 while locked, then relock on lane 0.
    wd = set_lane(rand_payload(8), 2, 8'hFB);
    step(wd, 16'h0004, I16D, I16C, 0, 0);
    check("mis_locked", 128'(lk8), 128'(0));
    check("mis_shift", 128'(sh8), 128'(4));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);
    check("mis_err", 128'(err8), 128'(1));
    check("mis_idle", {64'b0, od8}, {64'b0, 64'h0707070707070707});
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);
    check("mis_err_gone", 128'(err8), 128'(0));
    wd = set_lane(rand_payload(8), 0, 8'hFB);
    step(wd, 16'h0001, I16D, I16C, 0, 0);
    check("relock_locked", 128'(lk8), 128'(1));
    check("relock_cnt", 128'(cnt8), 128'(3));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);

    // Two Starts in one word: lane 0 wins, no error.
    wd = set_lane(set_lane(rand_payload(8), 0, 8'hFB), 4, 8'hFB);
    step(wd, 16'h0011, I16D, I16C, 0, 0);
    check("dual_shift", 128'(sh8), 128'(0));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);
    check("dual_err", 128'(err8), 128'(0));
    check("dual_sof", 128'(sof8), 128'(1));

    // Counter saturation and clear-wins.
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 1);
    check("clr_cnt", 128'(cnt8), 128'(0));
    for (int n = 0; n < 5; n++) begin
      wd = set_lane(rand_payload(8), seq[n], 8'hFB);
      step(wd, 16'h1 << seq[n], I16D, I16C, 0, 0);
      check("sat_cnt", 128'(cnt8), 128'(cexp[n]));
    end
    wd = set_lane(rand_payload(8), 0, 8'hFB);
    step(wd, 16'h0001, I16D, I16C, 0, 1);
    check("clr_wins", 128'(cnt8), 128'(0));
    step(rand_payload(8), 16'h0, I16D, I16C, 0, 0);

    // 16 lanes, Start in lane 8, then reset mid-frame.
    wd16 = set_lane(rand_payload(16), 8, 8'hFB);
    p8 = rand_payload(8);
    step(p8, 16'h0, wd16, 16'h0100, 0, 0);
    check("w16_shift", 128'(sh16), 128'(8));
    check("w16_locked", 128'(lk16), 128'(1));
    step(rand_payload(8), 16'h0, rand_payload(16), 16'h0, 0, 0);
    check("w16_lane0", 128'(od16[7:0]), 128'(8'hFB));
    check("w16_sof", 128'(sof16), 128'(1));
    step(rand_payload(8), 16'h0, rand_payload(16), 16'h0, 1, 0);
    check("w16_rst_idle", od16, I16D);
    check("w16_rst_locked", 128'(lk16), 128'(0));
    step(rand_payload(8), 16'h0, rand_payload(16), 16'h0, 0, 0);
    check("w16_post_idle", od16, I16D);
    step(rand_payload(8), 16'h0, rand_payload(16), 16'h0, 0, 0);
    check("w16_still_idle", od16, I16D);

    // Randomized traffic on both instances.
    for (int n = 0; n < NRAND; n++) begin
      gen_word(8, 4, p8, I8C);
      gen_word(16, 8, p16, I16C);
      step(p8, I8C, p16, I16C, ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xgmii_lane_align.md
XGMII_LANE_ALIGN -- requirements
Module: xgmii_lane_align

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning bytes per XGMII word; legal values are 4, 8, 16, 32.
REQ-002 SHALL have parameter ALIGN, default 4, meaning the lane granularity of legal Start positions; it SHALL divide LANES.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the realign counter width.
REQ-004 SHALL have port xgmii_rx_clk  in  1  as the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port sys_rst  in  1  as the reset, synchronous and active-high.
REQ-006 SHALL have port rx_data_i  in  8*LANES  carrying input data; lane n is bits [8n+7:8n] and lane 0 is first on the wire.
REQ-007 SHALL have port rx_ctrl_i  in  LANES  carrying input control flags; bit n belongs to lane n.
REQ-008 SHALL have port clr_cnt_i  in  1  which clears realign_cnt_o.
REQ-009 SHALL have port rx_data_o  out  8*LANES  carrying aligned data.
REQ-010 SHALL have port rx_ctrl_o  out  LANES  carrying aligned control flags.
REQ-011 SHALL have port sof_o  out  1  which is high when the output word carries Start in lane 0.
REQ-012 SHALL have port shift_o  out  $clog2(LANES)  giving the active lane shift.
REQ-013 SHALL have port locked_o  out  1  which is high in state LOCKED.
REQ-014 SHALL have port misalign_err_o  out  1  which is a one-cycle pulse on an illegal Start.
REQ-015 SHALL have port realign_cnt_o  out  CNT_W  holding a saturating count of shift changes.

Function
REQ-016 SHALL register the input word every cycle into a previous-word register (prev).
REQ-017 SHALL scan rx_ctrl_i/rx_data_i each cycle for Start (ctrl=1, data=0xFB); if several lanes carry Start, only the lowest-indexed lane p counts and the others are ignored with no error.
REQ-018 SHALL treat a Start as legal when p mod ALIGN == 0, and as illegal otherwise.
REQ-019 SHALL, on a legal Start, load shift <= p in the same edge that prev captures that word.
REQ-020 SHALL, when shift = s, form output lane k from the concatenated stream {current input, prev} at lane k+s of prev for k+s < LANES, else from current-input lane k+s-LANES; it SHALL register this result.
REQ-021 SHALL give every byte a fixed latency of 2 cycles, from input word N to output at cycle N+2, independent of shift.
REQ-022 SHALL implement a two-state FSM, HUNT and LOCKED, that resets to HUNT.
REQ-023 SHALL take HUNT -> LOCKED on a legal Start.
REQ-024 SHALL take LOCKED -> HUNT on an illegal Start.
REQ-025 SHALL, on a legal Start while LOCKED, stay LOCKED and apply the new shift.
REQ-026 SHALL, while in HUNT, drive rx_ctrl_o all ones and each rx_data_o lane to 0x07 (Idle); aligned data SHALL resume with the word containing the locking Start.
REQ-027 SHALL, on an illegal Start, output the word containing it and all later words as Idle until the next legal Start; shift SHALL be unchanged.
REQ-028 SHALL pulse misalign_err_o for 1 cycle, aligned with the output slot of the offending word (2-cycle latency); back-to-back illegal words SHALL give back-to-back pulses.
REQ-029 SHALL register sof_o with the data so that it is high exactly when rx_ctrl_o[0]=1, rx_data_o[7:0]=0xFB and the output is not forced Idle.
REQ-030 SHALL accept that the tail of the prior frame is lost on a shift change; lanes not yet emitted under the old shift are dropped with no error.
REQ-031 SHALL increment realign_cnt_o when a legal Start loads a value different from the current shift, or on any HUNT -> LOCKED transition; it SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-032 SHALL let clr_cnt_i win over a same-cycle increment, so the result is 0.
REQ-033 SHALL update shift_o and locked_o in the cycle after the Start word is presented.

Reset
REQ-034 SHALL, while sys_rst=1, drive rx_ctrl_o all ones, rx_data_o all 0x07, and set prev to Idle.
REQ-035 SHALL, while sys_rst=1, force sof_o=0, misalign_err_o=0, shift_o=0, locked_o=0, realign_cnt_o=0 and the FSM to HUNT.
REQ-036 SHALL let reset mid-frame take effect in the next cycle; in-flight words SHALL be discarded and Idle output SHALL persist until a legal Start after deassertion.

Verification
REQ-037 SHALL cover: LANES=8, Start in lane 0 at cycle T, then payload -> sof_o=1 at T+2 with lane-identical data, shift_o=0, locked_o=1, realign_cnt_o=1.
REQ-038 SHALL cover: LANES=8, Start in lane 4 with bytes 0xD5 in lanes 5-7 -> at T+2 lane 0=0xFB and lanes 1-3=0xD5, sof_o=1, shift_o=4.
REQ-039 SHALL cover: LANES=8, ALIGN=4, Start in lane 2 while LOCKED -> misalign_err_o pulse at T+2, Idle output, locked_o=0, shift unchanged; a later Start in lane 0 relocks.
REQ-040 SHALL cover: Start in lanes 0 and 4 of the same word -> shift=0 and no error.
REQ-041 SHALL cover: CNT_W=2, with shift alternated 0/4 five times -> realign_cnt_o saturates at 3; clr_cnt_i asserted on a change cycle gives 0.
REQ-042 SHALL cover: LANES=16, ALIGN=8, Start in lane 8 -> 2-cycle latency, shift_o=8; sys_rst asserted mid-frame -> Idle output and HUNT next cycle.
